circ_drain_accum: RTL and testbench
===================================

Name: circ_drain_accum

Overview:
- Consumer and reader for the circular_buffer: drives its `rd` input, samples its `dout`, and honours its `empty` flag.
- On a `start` pulse it drains exactly COUNT words from the buffer and accumulates them into an unsigned sum.
- It then presents the result with a one-cycle valid strobe.
- It sits between the circular_buffer read port and downstream checksum/statistics logic.

Parameters:
- DATA_W, 3, width of buffer read data (matches circular_buffer `dout`)
- COUNT, 8, words drained per batch (≥1)
- SUM_W, 7, accumulator/result width; the result wraps modulo 2^SUM_W

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous reset, active-low (reset==0 at a rising edge clears all state)
- start  input  1  begin a batch; sampled only in IDLE
- empty  input  1  circular_buffer `empty` flag
- rd  output  1  read request to circular_buffer `rd`
- din  input  DATA_W  read data from circular_buffer `dout`; valid the cycle after an accepted read
- busy  output  1  high from batch start until `sum_valid`
- sum  output  SUM_W  accumulated result; held until the next batch starts
- sum_valid  output  1  one-cycle strobe: `sum` is final
- sum_ovf  output  1  sticky per batch: accumulator wrapped at least once

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; `sum`, `sum_ovf`, `sum_valid`, `busy`, and the issue/receive counters are all 0.
  - `rd` is combinational and is forced 0 whenever reset==0.
  - A reset mid-batch abandons the batch; no `sum_valid` is produced.
- States: IDLE, READ, FLUSH, DONE.
- IDLE:
  - `rd`=0, `busy`=0.
  - start==1 → READ next cycle; `sum`, `sum_ovf` and both counters are cleared on that edge.
- READ:
  - `busy`=1.
  - rd = !empty && (issued < COUNT). An accepted read is rd==1 at a rising edge; `issued` increments.
  - After COUNT accepted reads → FLUSH.
- FLUSH:
  - `rd`=0.
  - Waits for the last outstanding read data, then → DONE.
- Read latency:
  - The buffer is registered-read: `din` is valid on the edge one cycle after an accepted read.
  - A 1-cycle valid pipe flag tracks this.
  - When the flag is set: `sum` <= `sum` + zero-extended `din`; `received` increments.
- Wrap:
  - The add is computed at SUM_W+1 bits. A carry out sets `sum_ovf`; `sum` keeps the low SUM_W bits.
- DONE:
  - `sum_valid`=1 for exactly one cycle; `busy` drops in the same cycle.
  - Next state IDLE.
  - `sum_valid` is asserted on the edge after the edge that captured the last word.
- empty==1 during READ:
  - `rd`=0; the block stalls with no timeout.
  - Data already in the valid pipe is still accumulated.
- Back-to-back reads:
  - With `empty` continuously 0, `rd` stays high for exactly COUNT consecutive cycles.
  - Batch latency is start edge → `sum_valid` = COUNT+3 cycles.
- Never reads an empty buffer. Never issues more than COUNT reads per batch.
- start==1 while busy: ignored; no restart and no effect on counters.
- start held high in IDLE/DONE: a new batch begins the cycle after DONE.
- `sum` is stable and readable from `sum_valid` until the next accepted start.

Test Plan:
1. Buffer preloaded with seven 3'b111 then one 3'b110, COUNT=8, start pulse:
   - `rd` high 8 consecutive cycles;
   - `sum_valid` exactly once, 11 cycles after start;
   - `sum`=55, `sum_ovf`=0, buffer `empty`=1 afterwards.
2. Eight words of 3'b111 with `empty` forced high for 3 cycles after word 4:
   - `rd` low during those 3 cycles; no read while empty;
   - final `sum`=56, `sum_valid` delayed by exactly 3 cycles versus scenario 1.
3. COUNT=20, SUM_W=7, twenty 3'b111:
   - raw total 140 → `sum`=12 (140−128), `sum_ovf`=1.
   - A following batch of eight 3'b001 → `sum`=8, `sum_ovf`=0.
4. start re-pulsed at cycle 3 and cycle 6 of a COUNT=8 batch:
   - exactly 8 reads total; single `sum_valid`; `sum` unaffected.
5. reset driven 0 for one cycle after 4 accepted reads:
   - next cycle `rd`=0, `busy`=0, `sum`=0, no `sum_valid`.
   - A new start drains the remaining 4 words (3'b010 each): `sum`=8 is not produced because only 4 words are available; `rd` stalls on `empty`, `busy` stays 1.
6. Consecutive batches with start held high, COUNT=2, data 1,2,3,4:
   - `sum_valid` pulses with `sum`=3 then `sum`=7;
   - exactly one IDLE cycle between them.

Source files
------------

// File: rtl/circ_drain_accum.sv
// Drains COUNT words from a registered-read circular buffer and accumulates them
// into a wrapping unsigned sum, then strobes sum_valid for one cycle.
module circ_drain_accum #(
  parameter int DATA_W = 3,
  parameter int COUNT  = 8,
  parameter int SUM_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              empty,
  output logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid,
  output logic              sum_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_received;
  logic               r_vld;
  logic [SUM_W-1:0]   r_sum;
  logic               r_ovf;
  logic               w_rd;
  logic               w_start;
  logic [SUM_W:0]     w_add;

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = READ;
      end
      READ: begin
        w_rd = !empty && (r_issued < LAST);
        if (w_rd && (r_issued == LAST_M1)) w_next = FLUSH;
      end
      FLUSH: begin
        if (r_received == LAST) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // rd is gated by reset so a held reset can never pop the buffer
  assign rd        = reset && w_rd;
  assign w_start   = (r_state == IDLE) && start;
  assign w_add     = {1'b0, r_sum} + (SUM_W + 1)'(din);
  assign busy      = (r_state == READ) || (r_state == FLUSH);
  assign sum_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign sum_ovf   = r_ovf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vld   <= rd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_issued   <= '0;
      r_received <= '0;
    end else if (w_start) begin
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      if (rd)    r_issued   <= r_issued + ONE;
      if (r_vld) r_received <= r_received + ONE;
    end
  end

  // Data arrives one edge after its read; the carry of the widened add marks a wrap
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (r_vld) begin
      r_sum <= w_add[SUM_W-1:0];
      r_ovf <= r_ovf | w_add[SUM_W];
    end
  end

endmodule

// File: tb/tb_circ_drain_accum.sv
// Randomized and directed bench for circ_drain_accum: a queue stands in for the
// circular buffer and a batch-level model predicts every output each cycle.
module tb_circ_drain_accum;

  localparam int DATA_W  = 3;
  localparam int COUNT   = 20;
  localparam int SUM_W   = 7;
  localparam int LATENCY = COUNT + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              empty = 1'b1;
  logic              rd;
  logic [DATA_W-1:0] din = '0;
  logic              busy;
  logic [SUM_W-1:0]  sum;
  logic              sumValid;
  logic              sumOvf;

  always #5 clock = ~clock;

  circ_drain_accum #(.DATA_W(DATA_W), .COUNT(COUNT), .SUM_W(SUM_W)) dut (
    .clock(clock), .reset(reset), .start(start), .empty(empty), .rd(rd),
    .din(din), .busy(busy), .sum(sum), .sum_valid(sumValid), .sum_ovf(sumOvf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bufQ[$];
  bit forceEmpty = 1'b0;

  bit mActive = 1'b0;
  int mIssued = 0;
  int mTotal = 0;
  int mDoneCyc = -1;
  int mSum = 0;
  int mOvf = 0;
  bit expRdEdge = 1'b0;
  bit dutRdEdge = 1'b0;

  int validCycQ[$];
  int validSumQ[$];
  int validOvfQ[$];
  int rdCount = 0;

  function automatic void check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endfunction

  function automatic int at(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Expected outputs come from batch bookkeeping: reads issued so far and the
  // cycle the result is due (three cycles after the last read)
  task automatic checkOutput();
    bit eRd, eBusy, eValid;
    eRd    = reset && mActive && (mIssued < COUNT) && !empty;
    eBusy  = mActive && (cyc != mDoneCyc);
    eValid = mActive && (cyc == mDoneCyc);
    check("rd", int'(rd), int'(eRd));
    check("busy", int'(busy), int'(eBusy));
    check("sum_valid", int'(sumValid), int'(eValid));
    if (!mActive || eValid) begin
      check("sum", int'(sum), mSum);
      check("sum_ovf", int'(sumOvf), mOvf);
    end
    expRdEdge = eRd;
    dutRdEdge = (rd === 1'b1);
    if (rd === 1'b1) rdCount++;
    if (sumValid === 1'b1) begin
      validCycQ.push_back(cyc);
      validSumQ.push_back(int'(sum));
      validOvfQ.push_back(int'(sumOvf));
    end
  endtask

  always @(negedge clock) checkOutput();

  task automatic endCycle();
    int word;
    @(posedge clock);
    #1;
    word = 0;
    if (expRdEdge && bufQ.size() > 0) word = bufQ[0];
    if (dutRdEdge && bufQ.size() > 0) din = DATA_W'(bufQ.pop_front());
    if (!reset) begin
      mActive  = 1'b0;
      mIssued  = 0;
      mDoneCyc = -1;
      mSum     = 0;
      mOvf     = 0;
    end else if (mActive) begin
      if (expRdEdge) begin
        mIssued++;
        mTotal += word;
        if (mIssued == COUNT) begin
          mDoneCyc = cyc + 3;
          mSum     = mTotal % (1 << SUM_W);
          mOvf     = (mTotal >= (1 << SUM_W)) ? 1 : 0;
        end
      end
      if (cyc == mDoneCyc) mActive = 1'b0;
    end else if (start) begin
      mActive  = 1'b1;
      mIssued  = 0;
      mTotal   = 0;
      mDoneCyc = -1;
    end
    cyc++;
  endtask

  task automatic setInputs(bit startV, bit resetV, bit forceV);
    start      = startV;
    reset      = resetV;
    forceEmpty = forceV;
    empty      = forceEmpty || (bufQ.size() == 0);
  endtask

  task automatic applyStimulus(bit startV, bit resetV, bit forceV);
    setInputs(startV, resetV, forceV);
    endCycle();
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic pushWords(int n, int v);
    repeat (n) bufQ.push_back(v);
  endtask

  initial begin
    int nv, rc, s;
    $display("[TB] start");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    setInputs(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("reset_rd", int'(rd), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_sum_valid", int'(sumValid), 0);
    check("reset_sum", int'(sum), 0);
    check("reset_sum_ovf", int'(sumOvf), 0);
    endCycle();
    idle(2);

    // twenty 7s: 140 wraps to 12
    pushWords(COUNT, 7);
    nv = validCycQ.size(); rc = rdCount; s = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(30);
    check("wrap_valid_count", validCycQ.size() - nv, 1);
    check("wrap_latency", at(validCycQ, nv) - s, LATENCY);
    check("wrap_sum", at(validSumQ, nv), 12);
    check("wrap_ovf", at(validOvfQ, nv), 1);
    check("wrap_reads", rdCount - rc, COUNT);
    check("wrap_buffer_drained", bufQ.size(), 0);

    // twenty 1s clears the sticky overflow
    pushWords(COUNT, 1);
    nv = validCycQ.size(); s = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(30);
    check("ones_valid_count", validCycQ.size() - nv, 1);
    check("ones_sum", at(validSumQ, nv), 20);
    check("ones_ovf", at(validOvfQ, nv), 0);

    // empty forced for 3 cycles after 4 reads
    pushWords(COUNT, 7);
    nv = validCycQ.size(); rc = rdCount; s = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    idle(30);
    check("stall_latency", at(validCycQ, nv) - s, LATENCY + 3);
    check("stall_sum", at(validSumQ, nv), 12);
    check("stall_reads", rdCount - rc, COUNT);

    // start re-pulsed while busy is ignored
    pushWords(COUNT, 3);
    nv = validCycQ.size(); rc = rdCount; s = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(30);
    check("repulse_valid_count", validCycQ.size() - nv, 1);
    check("repulse_latency", at(validCycQ, nv) - s, LATENCY);
    check("repulse_sum", at(validSumQ, nv), 60);
    check("repulse_reads", rdCount - rc, COUNT);

    // reset after 4 reads abandons the batch
    pushWords(COUNT, 2);
    nv = validCycQ.size();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setInputs(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("abort_rd", int'(rd), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sum", int'(sum), 0);
    endCycle();
    rc = rdCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(40);
    setInputs(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    check("starved_busy", int'(busy), 1);
    endCycle();
    check("starved_no_valid", validCycQ.size() - nv, 0);
    check("starved_reads", rdCount - rc, COUNT - 4);
    pushWords(4, 2);
    idle(10);
    check("refill_valid_count", validCycQ.size() - nv, 1);
    check("refill_sum", at(validSumQ, nv), 40);

    // start held high: back-to-back batches with one idle cycle between
    pushWords(COUNT, 1);
    pushWords(COUNT, 2);
    nv = validCycQ.size(); s = cyc;
    repeat (LATENCY + 2) applyStimulus(1'b1, 1'b1, 1'b0);
    idle(30);
    check("held_valid_count", validCycQ.size() - nv, 2);
    check("held_first_latency", at(validCycQ, nv) - s, LATENCY);
    check("held_gap", at(validCycQ, nv + 1) - at(validCycQ, nv), LATENCY + 1);
    check("held_sum1", at(validSumQ, nv), 20);
    check("held_sum2", at(validSumQ, nv + 1), 40);

    // randomized traffic, starts, empty glitches and rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0)
        bufQ.push_back((i < 750) ? int'($urandom_range(0, 7)) : int'($urandom_range(5, 7)));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 299) != 0,
                    $urandom_range(0, 5) == 0);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
